i2s_audio_tx: RTL and testbench

- Stereo I2S transmitter that drives the board's I2S pins: I2S_SDIN, I2S_SCLK, I2S_LRCLK and I2S_MCLK. These pins are currently tied low at top level.
- Sits directly downstream of the MemoryUnit. The CPU writes packed stereo samples through a memory-mapped register into an internal FIFO.
- The block serialises the samples in standard I2S format and raises a low-water interrupt so software can refill the FIFO.
- Runs entirely in the 50 MHz system clock domain; all audio clocks are derived by counters.

---
 rtl/fpgc_audio_pkg.sv | 36 +++
 rtl/audio_fifo.sv | 64 ++++++
 rtl/i2s_audio_tx.sv | 189 ++++++++++++++++++
 tb/tb_i2s_audio_tx.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpgc_audio_pkg.sv
// Shared types and constants for the FPGC audio path: stereo sample layout,
// transmitter state encoding and the per-bit I2S slot mapping.
`timescale 1ns/1ps
package fpgc_audio_pkg;

    localparam int BITS_PER_SLOT = 32;
    localparam int FRAME_BITS    = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } tx_state_t;

    typedef struct packed {
        logic [15:0] left;
        logic [15:0] right;
    } stereo_sample_t;

    // Serial bit for frame position b: the 16-bit word sits in slot bits 1..16,
    // one SCLK behind the LRCLK edge; every other slot bit is zero padding.
    function automatic logic slot_bit(input stereo_sample_t f, input logic [5:0] b);
        logic [4:0]  s;
        logic [4:0]  idx;
        logic [15:0] ch;
        s   = b[4:0];
        ch  = b[5] ? f.right : f.left;
        idx = 5'd16 - s;
        if (s >= 5'd1 && s <= 5'd16) begin
            slot_bit = ch[idx[3:0]];
        end else begin
            slot_bit = 1'b0;
        end
    endfunction

endpackage

// File: rtl/audio_fifo.sv
// Synchronous sample FIFO with an explicit level counter and a look-ahead
// head word (rd_data is valid whenever empty is low).
`timescale 1ns/1ps
module audio_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int unsigned DEPTH_U = DEPTH;
    localparam logic [PTR_W:0] FULL_LVL = DEPTH_U[PTR_W:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             wr_ok;
    logic             rd_ok;

    // Writes into a full FIFO and reads from an empty one are silently ignored.
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign full    = (count == FULL_LVL);
    assign empty   = (count == '0);
    assign level   = count;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/i2s_audio_tx.sv
// Stereo I2S transmitter: counter-derived MCLK/SCLK/LRCLK, 64-bit frames from a sample FIFO.
// Define I2S_UNDERRUN_COUNT_EN to add a saturating underrun counter (underrun_count/underrun_clr).
`timescale 1ns/1ps
module i2s_audio_tx
    import fpgc_audio_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int MCLK_HALF  = 2,
    parameter int SCLK_HALF  = 8,
    parameter int LOW_WATER  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [31:0]                   sample_data,
    input  logic                          sample_we,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          low_int,
    output logic                          underrun,
    output logic                          busy,
    output logic                          I2S_MCLK,
    output logic                          I2S_SCLK,
    output logic                          I2S_LRCLK,
    output logic                          I2S_SDIN,
`ifdef I2S_UNDERRUN_COUNT_EN
    input  logic                          underrun_clr,
    output logic [15:0]                   underrun_count,
`endif
    output tx_state_t                     state_dbg
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int MC_W  = $clog2(MCLK_HALF + 1);
    localparam int SC_W  = $clog2(SCLK_HALF + 1);
    localparam int BIT_W = $clog2(FRAME_BITS);

    localparam logic [MC_W-1:0]  MC_MAX   = MC_W'(MCLK_HALF - 1);
    localparam logic [SC_W-1:0]  SC_MAX   = SC_W'(SCLK_HALF - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] SLOT_R   = BIT_W'(BITS_PER_SLOT);
    localparam logic [LVL_W-1:0] LW_LVL   = LVL_W'(LOW_WATER);

    tx_state_t        state;
    logic [MC_W-1:0]  mclk_cnt;
    logic [SC_W-1:0]  sclk_cnt;
    logic [BIT_W-1:0] bit_idx;
    logic [BIT_W-1:0] next_b;
    stereo_sample_t   frame;
    stereo_sample_t   fifo_head;
    logic [31:0]      fifo_head_raw;
    logic             fifo_empty;
    logic             running;
    logic             fall_evt;
    logic             drain_done;
    logic             frame_start;
    logic             pop;
    logic             wr_accept;

    // sample_we is a one-cycle strobe with no ready: the word is taken only if
    // fifo_full is low in that same cycle, otherwise it is dropped.
    audio_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (sample_we),
        .wr_data (sample_data),
        .rd_en   (pop),
        .rd_data (fifo_head_raw),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign fifo_head = fifo_head_raw;
    assign busy      = running;
    assign state_dbg = state;

    // A "falling edge" is either the IDLE->RUN step or an SCLK 1->0 toggle.
    always_comb begin
        running = (state != IDLE);
        if (running) begin
            fall_evt = (sclk_cnt == SC_MAX) && I2S_SCLK;
            next_b   = (bit_idx == BIT_LAST) ? '0 : bit_idx + BIT_W'(1);
        end else begin
            fall_evt = enable;
            next_b   = '0;
        end
        drain_done  = (state == DRAIN) && !enable && fall_evt && (next_b == '0);
        frame_start = fall_evt && (next_b == '0) && !drain_done;
        pop         = frame_start && !fifo_empty;
        wr_accept   = sample_we && !fifo_full;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mclk_cnt  <= '0;
            sclk_cnt  <= '0;
            bit_idx   <= '0;
            frame     <= '0;
            I2S_MCLK  <= 1'b0;
            I2S_SCLK  <= 1'b0;
            I2S_LRCLK <= 1'b0;
            I2S_SDIN  <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            underrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state    <= RUN;
                        mclk_cnt <= '0;
                        sclk_cnt <= '0;
                        I2S_MCLK <= 1'b0;
                        I2S_SCLK <= 1'b0;
                    end
                end
                RUN, DRAIN: begin
                    if (drain_done) begin
                        state     <= IDLE;
                        mclk_cnt  <= '0;
                        sclk_cnt  <= '0;
                        bit_idx   <= '0;
                        I2S_MCLK  <= 1'b0;
                        I2S_SCLK  <= 1'b0;
                        I2S_LRCLK <= 1'b0;
                        I2S_SDIN  <= 1'b0;
                    end else begin
                        state <= enable ? RUN : DRAIN;
                        if (mclk_cnt == MC_MAX) begin
                            mclk_cnt <= '0;
                            I2S_MCLK <= ~I2S_MCLK;
                        end else begin
                            mclk_cnt <= mclk_cnt + 1'b1;
                        end
                        if (sclk_cnt == SC_MAX) begin
                            sclk_cnt <= '0;
                            I2S_SCLK <= ~I2S_SCLK;
                        end else begin
                            sclk_cnt <= sclk_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (fall_evt && !drain_done) begin
                bit_idx   <= next_b;
                I2S_LRCLK <= (next_b >= SLOT_R);
                I2S_SDIN  <= slot_bit(frame, next_b);
            end

            // An empty FIFO at frame start plays silence; a word written in the
            // same cycle stays queued for the next frame.
            if (frame_start) begin
                frame    <= fifo_empty ? '0 : fifo_head;
                underrun <= fifo_empty;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            low_int <= 1'b0;
        end else begin
            low_int <= (fifo_level == LW_LVL) && pop && !wr_accept;
        end
    end

`ifdef I2S_UNDERRUN_COUNT_EN
    logic [15:0] ur_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ur_count_q <= '0;
        end else if (underrun_clr) begin
            ur_count_q <= '0;
        end else if (underrun && ur_count_q != 16'hFFFF) begin
            ur_count_q <= ur_count_q + 16'd1;
        end
    end

    assign underrun_count = ur_count_q;
`endif

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Bench for i2s_audio_tx: decodes the I2S pins back into stereo words and
// scores them against a queue of accepted samples.
`timescale 1ns/1ps
module tb_i2s_audio_tx;
    import fpgc_audio_pkg::*;

    localparam int DEPTH = 16;
    localparam int LW    = 8;
    localparam int SH    = 8;
    localparam int MH    = 2;
    localparam logic [63:0] DATA_MASK = 64'h0001_FFFE_0001_FFFE;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] sample_data;
    logic        sample_we;
    logic        fifo_full;
    logic [4:0]  fifo_level;
    logic        low_int;
    logic        underrun;
    logic        busy;
    logic        I2S_MCLK;
    logic        I2S_SCLK;
    logic        I2S_LRCLK;
    logic        I2S_SDIN;
    tx_state_t   state_dbg;
`ifdef I2S_UNDERRUN_COUNT_EN
    logic        underrun_clr = 1'b0;
    logic [15:0] underrun_count;
`endif

    i2s_audio_tx #(
        .FIFO_DEPTH (DEPTH),
        .MCLK_HALF  (MH),
        .SCLK_HALF  (SH),
        .LOW_WATER  (LW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .sample_data (sample_data),
        .sample_we   (sample_we),
        .fifo_full   (fifo_full),
        .fifo_level  (fifo_level),
        .low_int     (low_int),
        .underrun    (underrun),
        .busy        (busy),
        .I2S_MCLK    (I2S_MCLK),
        .I2S_SCLK    (I2S_SCLK),
        .I2S_LRCLK   (I2S_LRCLK),
        .I2S_SDIN    (I2S_SDIN),
`ifdef I2S_UNDERRUN_COUNT_EN
        .underrun_clr   (underrun_clr),
        .underrun_count (underrun_count),
`endif
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];
    int mon_bit = 0;
    int mon_frames = 0;
    int mon_lowint = 0;
    int mon_busy_falls = 0;
    int mon_ur_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor: decode pins into frames ----------------
    initial begin : monitor
        logic        p_sclk;
        logic        p_mclk;
        logic        p_busy;
        logic [63:0] bits;
        logic [31:0] got;
        logic [31:0] exp_w;
        int          s_t;
        int          m_t;
        int          ur_cnt;
        int          last_ur;
        int          exp_ur;
        bit          ur_valid;
        p_sclk = 0; p_mclk = 0; p_busy = 0; bits = '0;
        s_t = 0; m_t = 0; ur_cnt = 0; last_ur = 0; ur_valid = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_bit = 0; bits = '0; ur_cnt = 0; ur_valid = 0;
                p_sclk = 0; p_mclk = 0; p_busy = 0;
            end else begin
                if (busy && !p_busy) begin
                    mon_bit = 0; bits = '0; ur_cnt = 0; ur_valid = 0;
                    s_t = cyc; m_t = cyc;
                end
                if (underrun) begin
                    ur_cnt++;
                    mon_ur_total++;
                    if (ur_valid) check("underrun_spacing", 64'(cyc - last_ur), 64'd1024);
                    last_ur = cyc;
                    ur_valid = 1;
                end
                if (low_int) begin
                    mon_lowint++;
                    check("low_int_level", 64'(fifo_level), 64'(LW - 1));
                end
                if (!busy) begin
                    check("idle_pins", {I2S_MCLK, I2S_SCLK, I2S_LRCLK, I2S_SDIN}, 64'd0);
                end else begin
                    if (I2S_MCLK !== p_mclk) begin
                        check("mclk_half", 64'(cyc - m_t), 64'(MH));
                        m_t = cyc;
                    end
                    if (I2S_SCLK !== p_sclk) begin
                        check("sclk_half", 64'(cyc - s_t), 64'(SH));
                        s_t = cyc;
                        if (I2S_SCLK) begin
                            check("lrclk", 64'(I2S_LRCLK), 64'(mon_bit >= 32));
                            bits[mon_bit] = I2S_SDIN;
                            if (mon_bit == 63) begin
                                for (int i = 0; i < 16; i++) begin
                                    got[31-i] = bits[1+i];
                                    got[15-i] = bits[33+i];
                                end
                                if (exp_q.size() > 0) begin
                                    exp_w = exp_q.pop_front();
                                    exp_ur = 0;
                                    ur_valid = 0;
                                end else begin
                                    exp_w = '0;
                                    exp_ur = 1;
                                end
                                check("frame_data", 64'(got), 64'(exp_w));
                                check("frame_pad", bits & ~DATA_MASK, 64'd0);
                                check("frame_underrun", 64'(ur_cnt), 64'(exp_ur));
                                mon_frames++;
                                mon_bit = 0;
                                bits = '0;
                                ur_cnt = 0;
                            end else begin
                                mon_bit++;
                            end
                        end
                    end
                end
                if (p_busy && !busy) mon_busy_falls++;
                p_busy = busy;
                p_sclk = I2S_SCLK;
                p_mclk = I2S_MCLK;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic write_sample(input logic [31:0] d);
        @(negedge clk);
        sample_data = d;
        sample_we = 1'b1;
        if (exp_q.size() < DEPTH) exp_q.push_back(d);
        @(negedge clk);
        sample_we = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int target;
        bit ok;
        target = mon_frames + n;
        ok = 0;
        for (int c = 0; c < (n + 1) * 1100; c++) begin
            @(negedge clk);
            if (mon_frames >= target) begin
                ok = 1;
                break;
            end
        end
        check("wait_frames_timeout", 64'(ok), 64'd1);
    endtask

    task automatic wait_bit(input int b);
        bit ok;
        ok = 0;
        for (int c = 0; c < 2200; c++) begin
            @(negedge clk);
            if (busy && mon_bit == b) begin
                ok = 1;
                break;
            end
        end
        check("wait_bit_timeout", 64'(ok), 64'd1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int c = 0; c < 1200; c++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        check("wait_idle_timeout", 64'(ok), 64'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stimulus
        int n;
        int f0;
        int bf;
        int lw0;
        int ur0;
        int exp_low;
        reset = 1'b1;
        enable = 1'b0;
        sample_we = 1'b0;
        sample_data = '0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {fifo_full, low_int, underrun, busy, I2S_MCLK, I2S_SCLK, I2S_LRCLK, I2S_SDIN}, 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_state", 64'(state_dbg), 64'(IDLE));
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Directed pattern: one known word then silence.
        write_sample(32'h8001_7FFE);
        check("level_one", 64'(fifo_level), 64'd1);
        enable = 1'b1;
        wait_frames(2);
        enable = 1'b0;
        wait_idle();

        // Empty FIFO: one underrun per frame, silent data.
        ur0 = mon_ur_total;
        enable = 1'b1;
        wait_frames(3);
        enable = 1'b0;
        wait_idle();
        check("underrun_count_empty", 64'(mon_ur_total - ur0), 64'd3);

        // Overfill while idle: 17th word dropped, low-water once.
        for (int i = 0; i < 17; i++) write_sample($urandom());
        check("full_level", 64'(fifo_level), 64'd16);
        check("full_flag", 64'(fifo_full), 64'd1);
        lw0 = mon_lowint;
        enable = 1'b1;
        wait_frames(17);
        enable = 1'b0;
        wait_idle();
        check("low_int_once", 64'(mon_lowint - lw0), 64'd1);
        check("drained_level", 64'(fifo_level), 64'd0);

        // Drain: disable mid-frame finishes that frame only.
        for (int i = 0; i < 3; i++) write_sample($urandom());
        f0 = mon_frames;
        enable = 1'b1;
        wait_bit(10);
        enable = 1'b0;
        wait_idle();
        check("drain_one_frame", 64'(mon_frames - f0), 64'd1);
        check("drain_state_idle", 64'(state_dbg), 64'(IDLE));
        // Re-enable during drain: no gap between frames.
        enable = 1'b1;
        wait_bit(10);
        enable = 1'b0;
        wait_bit(20);
        check("drain_state", 64'(state_dbg), 64'(DRAIN));
        bf = mon_busy_falls;
        enable = 1'b1;
        wait_frames(2);
        check("drain_no_gap", 64'(mon_busy_falls - bf), 64'd0);
        enable = 1'b0;
        wait_idle();

        // Asynchronous reset mid-frame.
        for (int i = 0; i < 2; i++) write_sample($urandom());
        enable = 1'b1;
        wait_frames(1);
        wait_bit(40);
        #3 reset = 1'b1;
        #1;
        check("async_rst_pins", {busy, underrun, low_int, fifo_full, I2S_MCLK, I2S_SCLK, I2S_LRCLK, I2S_SDIN}, 64'd0);
        check("async_rst_level", 64'(fifo_level), 64'd0);
        exp_q.delete();
        enable = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_state", 64'(state_dbg), 64'(IDLE));
        check("post_rst_busy", 64'(busy), 64'd0);

        // Randomised rounds.
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(0, 10);
            for (int i = 0; i < n; i++) begin
                write_sample($urandom());
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            check("rand_level", 64'(fifo_level), 64'(exp_q.size()));
            check("rand_full", 64'(fifo_full), 64'(exp_q.size() == DEPTH));
            exp_low = (exp_q.size() >= LW) ? 1 : 0;
            lw0 = mon_lowint;
            enable = 1'b1;
            wait_frames(exp_q.size() + 1);
            enable = 1'b0;
            wait_idle();
            check("rand_low_int", 64'(mon_lowint - lw0), 64'(exp_low));
            check("rand_level_end", 64'(fifo_level), 64'd0);
        end

`ifdef I2S_UNDERRUN_COUNT_EN
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        check("cnt_cleared", 64'(underrun_count), 64'd0);
        enable = 1'b1;
        wait_frames(3);
        check("cnt_three", 64'(underrun_count), 64'd3);
        for (int c = 0; c < 1100; c++) begin
            @(negedge clk);
            if (underrun) break;
        end
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        check("cnt_clr_wins", 64'(underrun_count), 64'd0);
        force dut.ur_count_q = 16'hFFFD;
        #1;
        release dut.ur_count_q;
        wait_frames(4);
        check("cnt_saturate", 64'(underrun_count), 64'hFFFF);
        enable = 1'b0;
        wait_idle();
`endif

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #3_000_000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
